// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the RIOT RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned RAM_AW    = 6;
    localparam int unsigned RAM_DW    = 8;
    localparam int unsigned RAM_DEPTH = 64;

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_ISSUED = 2'd1,
        H_ACK    = 2'd2
    } host_state_t;

    typedef enum logic [1:0] {
        SRC_CPU  = 2'd0,
        SRC_HOST = 2'd1,
        SRC_CLR  = 2'd2
    } src_t;

    // Access issued in one cycle, completed from this record in the next.
    typedef struct packed {
        logic              valid;
        logic              we;
        src_t              src;
        logic [RAM_DW-1:0] wdata;
    } issue_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset address walker: steps through every RAM address once.
module ram_clear_seq
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [RAM_AW-1:0] addr,
    output logic              active,
    output logic              done
);

    // Counter advances only when its address was actually issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            active <= 1'b1;
            done   <= 1'b0;
        end else if (advance && active) begin
            addr <= RAM_AW'(addr + 1'b1);
            if (addr == RAM_AW'(RAM_DEPTH - 1)) begin
                active <= 1'b0;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer for the 64x8 RIOT RAM: CPU > clear > host.
// Optional post-reset zero fill enabled by defining RAM_ARB_CLEAR_EN.
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_sel,
    input  logic              cpu_rw,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    output logic [RAM_DW-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [RAM_AW-1:0] host_addr,
    input  logic [RAM_DW-1:0] host_wdata,
    output logic              host_ack,
    output logic [RAM_DW-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we_n,
    output logic [RAM_AW-1:0] ram_a,
    output logic [RAM_DW-1:0] ram_di,
    input  logic [RAM_DW-1:0] ram_do,
    input  logic              ram_oe,
    output logic              busy
);

    host_state_t       h_state, h_next;
    logic              host_ack_nxt;
    logic              host_grant_c;
    issue_t            issue_c, pend;
    logic [RAM_AW-1:0] issue_addr;
    logic              clr_active;
    logic [RAM_AW-1:0] clr_addr;
    logic              busy_q;

`ifdef RAM_ARB_CLEAR_EN
    logic clr_advance;
    logic clr_done;

    assign clr_advance = clr_active & ~cpu_sel & ~rst;

    ram_clear_seq u_clear (
        .clk     (clk),
        .rst     (rst),
        .advance (clr_advance),
        .addr    (clr_addr),
        .active  (clr_active),
        .done    (clr_done)
    );

    // busy trails the walker by one cycle so it covers the last commit.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= 1'b1;
        else     busy_q <= ~clr_done;
    end
`else
    assign clr_active = 1'b0;
    assign clr_addr   = '0;
    assign busy_q     = 1'b0;
`endif

    assign busy = busy_q;

    // Pick this cycle's winner and build its issue record.
    always_comb begin
        issue_c      = '0;
        issue_addr   = '0;
        host_grant_c = 1'b0;
        if (!rst) begin
            if (cpu_sel) begin
                issue_c.valid = 1'b1;
                issue_c.we    = ~cpu_rw;
                issue_c.src   = SRC_CPU;
                issue_c.wdata = cpu_rw ? '0 : cpu_wdata;
                issue_addr    = cpu_addr;
            end else if (clr_active) begin
                issue_c.valid = 1'b1;
                issue_c.we    = 1'b1;
                issue_c.src   = SRC_CLR;
                issue_addr    = clr_addr;
            end else if (h_state == H_IDLE && host_req && !busy_q) begin
                issue_c.valid = 1'b1;
                issue_c.we    = host_we;
                issue_c.src   = SRC_HOST;
                issue_c.wdata = host_we ? host_wdata : '0;
                issue_addr    = host_addr;
                host_grant_c  = 1'b1;
            end
        end
    end

    // RAM pins: address from the issuing access, strobe/data from the completing one.
    assign ram_en   = ~rst & (issue_c.valid | pend.valid);
    assign ram_we_n = ~(~rst & pend.valid & pend.we);
    assign ram_a    = issue_addr;
    assign ram_di   = rst ? '0 : pend.wdata;

    // Complete-phase register and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            host_rdata <= '0;
        end else begin
            pend       <= issue_c;
            cpu_rvalid <= pend.valid & ~pend.we & (pend.src == SRC_CPU);
            if (pend.valid && !pend.we && pend.src == SRC_CPU && ram_oe)
                cpu_rdata <= ram_do;
            if (pend.valid && !pend.we && pend.src == SRC_HOST && ram_oe)
                host_rdata <= ram_do;
        end
    end

    // Host FSM state and registered ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_state  <= H_IDLE;
            host_ack <= 1'b0;
        end else begin
            h_state  <= h_next;
            host_ack <= host_ack_nxt;
        end
    end

    // Host FSM next state: grant, wait for completion, ack.
    always_comb begin
        h_next       = h_state;
        host_ack_nxt = 1'b0;
        case (h_state)
            H_IDLE:   if (host_grant_c) h_next = H_ISSUED;
            H_ISSUED: begin
                h_next       = H_ACK;
                host_ack_nxt = 1'b1;
            end
            H_ACK:    h_next = H_IDLE;
            default:  h_next = H_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural split-timing RAM.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_sel = 1'b0, cpu_rw = 1'b0;
    logic [5:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_rvalid;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [5:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       ram_en, ram_we_n;
    logic [5:0] ram_a;
    logic [7:0] ram_di;
    logic [7:0] ram_do = '0;
    logic       ram_oe = 1'b0;
    logic       busy;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         rd;
    } exp_t;

    exp_t       cpu_q[$];
    exp_t       host_q[$];
    logic [7:0] mem    [64];
    logic [7:0] shadow [64];
    logic [5:0] addr_q = '0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_sel    (cpu_sel),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .ram_en     (ram_en),
        .ram_we_n   (ram_we_n),
        .ram_a      (ram_a),
        .ram_di     (ram_di),
        .ram_do     (ram_do),
        .ram_oe     (ram_oe),
        .busy       (busy)
    );

    // RAM model: address latched on posedge, write/read resolved at the next negedge.
    initial for (int i = 0; i < 64; i++) mem[i] = 8'(i * 5 + 3);
    always @(posedge clk) if (ram_en) addr_q <= ram_a;
    always @(negedge clk) begin
        ram_oe <= 1'b0;
        if (ram_en && !ram_we_n) mem[addr_q] <= ram_di;
        else if (ram_en) begin
            ram_do <= mem[addr_q];
            ram_oe <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pop and compare responses as the DUT produces them.
    task automatic monitor();
        exp_t e;
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) check("cpu_rvalid_spurious", 32'(cpu_rvalid), 0);
            else begin
                e = cpu_q.pop_front();
                check("cpu_rvalid_cycle", 32'(cyc), 32'(e.due));
                check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
            end
        end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
            check("cpu_rvalid_missing", 32'(cpu_rvalid), 1);
            void'(cpu_q.pop_front());
        end
        if (host_ack) begin
            if (host_q.size() == 0) check("host_ack_spurious", 32'(host_ack), 0);
            else begin
                e = host_q.pop_front();
                check("host_ack_cycle", 32'(cyc), 32'(e.due));
                if (e.rd) check("host_rdata", 32'(host_rdata), 32'(e.data));
            end
        end else if (host_q.size() > 0 && host_q[0].due <= cyc) begin
            check("host_ack_missing", 32'(host_ack), 1);
            void'(host_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
        cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_wdata = d;
        shadow[a] = d;
        tick();
    endtask

    task automatic cpu_rd(input logic [5:0] a);
        exp_t e;
        cpu_sel = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
        e.due = cyc + 2; e.data = shadow[a]; e.rd = 1'b1;
        cpu_q.push_back(e);
        tick();
    endtask

    task automatic drain();
        cpu_sel = 1'b0;
        repeat (4) tick();
    endtask

    // Host grant expected in the current cycle; wait a bounded time for the ack.
    task automatic wait_host_ack(input logic [7:0] exp_data, input bit rd);
        exp_t e;
        bit   got = 1'b0;
        e.due = cyc + 2; e.data = exp_data; e.rd = rd;
        host_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("host_ack_timeout", 32'(got), 1);
        host_req = 1'b0;
    endtask

    task automatic host_access(input bit we, input logic [5:0] a, input logic [7:0] d);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        if (we) shadow[a] = d;
        wait_host_ack(shadow[a], !we);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) shadow[i] = 8'(i * 5 + 3);

        // Reset values
        tick();
        tick();
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_we_n", 32'(ram_we_n), 1);
        check("rst_ram_a", 32'(ram_a), 0);
        check("rst_ram_di", 32'(ram_di), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst_host_ack", 32'(host_ack), 0);
        check("rst_host_rdata", 32'(host_rdata), 0);

`ifdef RAM_ARB_CLEAR_EN
        check("rst_busy", 32'(busy), 1);
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                rst = 1'b1;
                tick();
            end
            rst = 1'b0;
            host_req = (p == 1); host_we = 1'b0; host_addr = 6'd0;
            n = 0;
            for (int k = 0; k < 200; k++) begin
                if (!busy) break;
                n++;
                if (p == 1 && k >= 10 && k <= 12) begin
                    cpu_sel = 1'b1; cpu_rw = 1'b0;
                    cpu_addr = 6'(k - 7); cpu_wdata = 8'(8'h91 + k - 10);
                end else cpu_sel = 1'b0;
                tick();
            end
            cpu_sel = 1'b0;
            check("busy_len", 32'(n), (p == 1) ? 68 : 65);
            for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
            if (p == 1) begin
                shadow[3] = 8'h91; shadow[4] = 8'h92; shadow[5] = 8'h93;
                wait_host_ack(8'h00, 1'b1);
            end
        end
        for (int a = 0; a < 64; a++) cpu_rd(6'(a));
        drain();
`else
        check("busy_off", 32'(busy), 0);
        rst = 1'b0;
        host_access(1'b1, 6'h05, 8'h5C);
        tick();
`endif

        // Host write then read at the top address
        host_access(1'b1, 6'h3F, 8'hA5);
        tick();
        host_access(1'b0, 6'h3F, 8'h00);
        tick();

        // CPU back-to-back writes then reads
        cpu_wr(6'h00, 8'h11);
        cpu_wr(6'h01, 8'h22);
        cpu_rd(6'h00);
        cpu_rd(6'h01);
        drain();
        check("mem_00", 32'(mem[0]), 32'h11);
        check("mem_01", 32'(mem[1]), 32'h22);

        // Host starved while cpu_sel is held, granted the cycle it falls
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'h00;
        for (int k = 0; k < 5; k++) cpu_rd(6'h01);
        cpu_sel = 1'b0;
        wait_host_ack(shadow[0], 1'b1);
        drain();

        // Reset in the complete phase of a host write
        cpu_wr(6'h10, 8'h33);
        cpu_sel = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'h10; host_wdata = 8'h77;
        tick();
        host_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        for (int k = 0; k < 200; k++) begin
            if (!busy) break;
            tick();
        end
        check("busy_after_rst", 32'(busy), 0);
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_ack_after_rst", 32'(host_ack), 0);
        end
        check("mem_10_not_77", 32'(mem[16] == 8'h77), 0);
        cpu_rd(6'h10);
        drain();

        // Mixed random CPU traffic
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) cpu_wr(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
            else                          cpu_rd(6'($urandom_range(0, 63)));
        end
        drain();
        check("cpu_q_empty", 32'(cpu_q.size()), 0);
        check("host_q_empty", 32'(host_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencer and arbiter for the 64 x 8 RIOT RAM macro. Shares the RAM between the CPU bus decode (absolute priority, no stall available) and a host/debug port with a req/ack handshake. Hides the RAM's split timing: address is captured on posedge, and the write commits on the following negedge. Optionally zero-fills the RAM after reset.

## Interface
- AW, 6: RAM address width.
- DW, 8: RAM data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_sel  in  1  CPU RAM access this cycle
- cpu_rw  in  1  1 = read, 0 = write
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  last CPU read data, held
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata updated
- host_req  in  1  host request, level, fields stable until ack
- host_we  in  1  1 = write
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DW  host read data, valid with ack
- ram_en  out  1  RAM enable
- ram_we_n  out  1  RAM write strobe, active low
- ram_a  out  AW  RAM address
- ram_di  out  DW  RAM write data
- ram_do  in  DW  RAM read data
- ram_oe  in  1  RAM output valid
- busy  out  1  clear sequence in progress

## Operation
- Access issued in cycle T (issue phase):
  - ram_en=1 and ram_a=addr, combinational from the current winner.
  - The RAM captures the address at the end of T.
- Cycle T+1 (complete phase), driven from registered issue info:
  - Write: ram_en=1, ram_we_n=0, ram_di=registered wdata. Commits at the negedge.
  - Read: ram_en=1, ram_we_n=1. ram_do is captured at the end of T+1, qualified by ram_oe.
- Issue and complete phases overlap, so one access can be issued every cycle. ram_we_n always reflects the access issued in the previous cycle.
- Idle cycle: ram_en=0, ram_we_n=1.
- Priority: cpu_sel > clear > host. The CPU is never delayed. The host can be starved by continuous cpu_sel; this is accepted.
- Host FSM H_IDLE → H_ISSUED → H_ACK → H_IDLE:
  - Grant happens in H_IDLE when host_req=1, cpu_sel=0 and not busy.
  - In H_ACK, host_ack=1; for reads host_rdata is valid in the same cycle.
  - host_req sampled in H_IDLE after an ack is treated as a new request.
- CPU read: cpu_rdata updated and cpu_rvalid=1 in T+2. Writes produce no response.

## Timing
- Read latency: 2 cycles from issue to cpu_rvalid or host_ack.
- Write commit: negedge inside T+1. Host ack for a write arrives at T+2.
- Host throughput: 1 access per 3 cycles. CPU throughput: 1 access per cycle.
- Reset values:
  - ram_en=0, ram_we_n=1, ram_a=0, ram_di=0.
  - cpu_rdata=0, cpu_rvalid=0, host_ack=0, host_rdata=0.
  - Host FSM in H_IDLE.
  - busy=1 with clear enabled, otherwise 0.
- Reset while rst=1: RAM outputs are forced inactive. A complete phase pending at the reset edge is dropped, so no write commits and no ack or rvalid is issued.
- ram_a wraps naturally at AW bits; no out-of-range case exists.

## Configuration
- RAM_ARB_CLEAR_EN defined: after rst deasserts, the clear walker writes 0x00 to addresses 0..63 in order.
  - One address is issued per cycle in which cpu_sel=0. The counter holds when the CPU wins.
  - busy falls the cycle after the commit of address 63.
  - No host grant while busy=1.
  - CPU writes during the clear are not overwritten if their address has already been cleared. Otherwise the walker overwrites them, and this is accepted.
- RAM_ARB_CLEAR_EN undefined: no walker, busy tied 0, and RAM contents after reset are undefined.

## Structure
- Package ram_arb_pkg:
  - constants RAM_AW=6, RAM_DW=8, RAM_DEPTH=64;
  - host FSM state enum;
  - issue-record struct {valid, we, src (CPU/HOST/CLR), wdata}.
- Sub-module ram_clear_seq: 6-bit counter with advance input, addr/active/done outputs. Instantiated only under RAM_ARB_CLEAR_EN.

## Test plan
- Host write 0x3F←0xA5, then host read 0x3F → ack at T+2 of each access; host_rdata=0xA5 on the read ack.
- CPU writes 0x00←0x11 and 0x01←0x22 in consecutive cycles, then CPU reads both → each write commits to the correct address; cpu_rvalid pulses with 0x11, then 0x22.
- host_req held with cpu_sel=1 for 5 cycles → no host grant during those cycles; grant the cycle cpu_sel falls; ack 2 cycles later.
- rst asserted in the complete phase of a write to 0x10 (value 0x77) → read of 0x10 afterwards does not return 0x77; no ack is issued.
- With RAM_ARB_CLEAR_EN: busy stays high 64 cycles plus 1 with cpu_sel=0; all 64 bytes read 0x00. Inserting 3 CPU cycles extends busy by exactly 3.
- Without RAM_ARB_CLEAR_EN: busy=0 from reset; a host request in the first cycle after reset is granted immediately.
